// File: rtl/conv_pkg.sv
// Shared widths and lane helpers for the 3x3 convolution MAC.
// A window or weight beat is nine lanes, row-major, lane 0 in the low bits.
package conv_pkg;

  localparam int PIXELS_PER_WINDOW  = 9;
  localparam int CONV_PIXEL_WIDTH   = 8;
  localparam int CONV_WEIGHT_WIDTH  = 8;
  localparam int CONV_PRODUCT_WIDTH = CONV_PIXEL_WIDTH + CONV_WEIGHT_WIDTH;
  localparam int CONV_ACC_WIDTH     = 20;
  localparam int CONV_ID_WIDTH      = 3;
  localparam int CONV_STREAM_WIDTH  = PIXELS_PER_WINDOW * CONV_PIXEL_WIDTH;

  function automatic logic [CONV_PIXEL_WIDTH-1:0] pixel(
    input logic [CONV_STREAM_WIDTH-1:0] data,
    input int                           k
  );
    return data[k*CONV_PIXEL_WIDTH +: CONV_PIXEL_WIDTH];
  endfunction

  function automatic logic signed [CONV_WEIGHT_WIDTH-1:0] weight(
    input logic [CONV_STREAM_WIDTH-1:0] data,
    input int                           k
  );
    return data[k*CONV_WEIGHT_WIDTH +: CONV_WEIGHT_WIDTH];
  endfunction

endpackage

// File: rtl/conv_mul_lane.sv
// One registered unsigned-pixel x signed-weight multiplier lane.
// The product register only loads when a window is accepted.
module conv_mul_lane #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int PRODUCT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic        [PIXEL_WIDTH-1:0]   pix,
  input  logic signed [WEIGHT_WIDTH-1:0]  wgt,
  output logic signed [PRODUCT_WIDTH-1:0] product
);

  // Zero-extend the pixel so it multiplies as a non-negative signed value.
  logic signed [PIXEL_WIDTH+WEIGHT_WIDTH:0] full;

  assign full = $signed({1'b0, pix}) * wgt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      product <= '0;
    end else if (en) begin
      product <= PRODUCT_WIDTH'(full);
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 window x weight-set multiply-accumulate: multiply, pairwise add, final sum.
// All three stages advance together under a single global stall.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int STREAM_DATA_WIDTH = CONV_STREAM_WIDTH,
  parameter int PIXEL_WIDTH       = CONV_PIXEL_WIDTH,
  parameter int WEIGHT_WIDTH      = CONV_WEIGHT_WIDTH,
  parameter int ACC_WIDTH         = CONV_ACC_WIDTH,
  parameter int ID_WIDTH          = CONV_ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          weight_wr,
  input  logic [STREAM_DATA_WIDTH-1:0]  weight_data,
  output logic                          weights_loaded,
  input  logic [STREAM_DATA_WIDTH-1:0]  in_data,
  input  logic                          in_valid,
  output logic                          in_rdy,
  input  logic [ID_WIDTH-1:0]           in_id,
  output logic signed [ACC_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_rdy,
  output logic [ID_WIDTH-1:0]           out_id
);

  localparam int PRODUCT_WIDTH = PIXEL_WIDTH + WEIGHT_WIDTH;

  logic [STREAM_DATA_WIDTH-1:0]     weight_set;
  logic                             advance;
  logic                             accept;
  logic                             s1_valid;
  logic                             s2_valid;
  logic [ID_WIDTH-1:0]              s1_id;
  logic [ID_WIDTH-1:0]              s2_id;
  logic signed [PRODUCT_WIDTH-1:0]  prod [PIXELS_PER_WINDOW];
  logic signed [ACC_WIDTH-1:0]      partial [5];

  assign advance = ~out_valid | out_rdy;
  assign in_rdy  = weights_loaded & advance & ~weight_wr;
  assign accept  = in_valid & in_rdy;

  // Products are formed with the weights live at acceptance, so a later
  // weight load never disturbs windows already in the pipe.
  for (genvar k = 0; k < PIXELS_PER_WINDOW; k++) begin : g_lane
    conv_mul_lane #(
      .PIXEL_WIDTH   (PIXEL_WIDTH),
      .WEIGHT_WIDTH  (WEIGHT_WIDTH),
      .PRODUCT_WIDTH (PRODUCT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (accept),
      .pix     (pixel(in_data, k)),
      .wgt     (weight(weight_set, k)),
      .product (prod[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      weight_set     <= '0;
      weights_loaded <= 1'b0;
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      out_valid      <= 1'b0;
      s1_id          <= '0;
      s2_id          <= '0;
      out_id         <= '0;
      out_data       <= '0;
      for (int i = 0; i < 5; i++) partial[i] <= '0;
    end else begin
      if (weight_wr) begin
        weight_set     <= weight_data;
        weights_loaded <= 1'b1;
      end
      if (advance) begin
        s1_valid  <= accept;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
        if (accept) s1_id <= in_id;
        if (s1_valid) begin
          s2_id <= s1_id;
          for (int i = 0; i < 4; i++) begin
            partial[i] <= ACC_WIDTH'(prod[2*i]) + ACC_WIDTH'(prod[2*i+1]);
          end
          partial[4] <= ACC_WIDTH'(prod[8]);
        end
        // Result registers only load on a real window; bubbles leave them as-is.
        if (s2_valid) begin
          out_id   <= s2_id;
          out_data <= partial[0] + partial[1] + partial[2] + partial[3] + partial[4];
        end
      end
    end
  end

endmodule
